arbitro_rr: RTL
===============

# arbitro_rr

Weighted round-robin scheduler that drains four class queues (FIFOs 0..3) into one shared downstream FIFO. It sits on the merge side of the class-routing path, mirroring the class-split arbiter: pops at most one input queue per cycle, drives the 4:1 data-mux select, and pushes into the downstream FIFO one cycle later. It stalls on downstream `almost_full`. Each queue may take up to `WEIGHT` consecutive grants before ownership rotates.

## Interface
- `WEIGHT`, default 2: maximum consecutive grants per queue before rotation; legal range 1..15.
- `CNT_W`, default `$clog2(WEIGHT+1)`: burst-counter width; derived, not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `empty`  in  4  per-queue empty flags from input FIFOs 0..3.
- `almost_full`  in  1  downstream FIFO almost-full flag.
- `pop`  out  4  one-hot (or zero) read strobe to input FIFOs; combinational.
- `sel`  out  2  registered mux select, index of the queue popped last cycle.
- `push`  out  1  registered write strobe to downstream FIFO.
- `idle`  out  1  registered; high when in IDLE state.

## Operation
- State registers: `cur` (2 b, owning queue), `cnt` (CNT_W b, grants used by `cur`), FSM `state`.
- FSM states and transitions:
  - IDLE: entered on reset. Goes to ACTIVE when `empty != 4'hF` and `!almost_full`.
  - ACTIVE: `pop` may assert. Goes to STALL on `almost_full`; else to IDLE when `empty == 4'hF`.
  - STALL: no pops. Goes to ACTIVE when `!almost_full` and any queue is non-empty; goes to IDLE when `!almost_full` and all queues are empty.
- Grant `g`:
  - `g = cur` if `!empty[cur]`.
  - Otherwise, the first non-empty queue searching `cur+1`, `cur+2`, `cur+3` (mod 4).
- `pop[g] = (state==ACTIVE) & !almost_full & !empty[g]`; all other bits 0.
- On a pop of `g`:
  - `n = (g==cur ? cnt : 0) + 1`.
  - If `n == WEIGHT`: `cur <= g+1` (mod 4), `cnt <= 0`.
  - Else: `cur <= g`, `cnt <= n`.
- Without a pop, `cur` and `cnt` hold.
- `almost_full` gates `pop` combinationally in the same cycle, even before the FSM reaches STALL.
- An empty owner forfeits its remaining burst immediately; there is no waiting.

## Timing
- Reset values: `pop` = 0, `push` = 0, `sel` = 0, `idle` = 1, `cur` = 0, `cnt` = 0, state IDLE.
- `reset` asserted mid-burst:
  - Clears all state at the next edge.
  - Forces `pop` = 0 in the same cycle.
  - A `push` already registered for that edge is dropped.
- Pop-to-push latency is 1 cycle: `push(t+1) = |pop(t)` and `sel(t+1) = g(t)`. This matches FIFO read latency 1, so data and `push` align at the downstream FIFO.
- Throughput: one pop per cycle in ACTIVE.
- First pop occurs one cycle after the IDLE→ACTIVE edge.
- Downstream headroom: the almost-full threshold must cover at least 1 in-flight push.
- Simultaneous `almost_full` rise and last-entry pop: the pop is suppressed and the entry remains queued.
- Wrap-around: `cur` 3 + 1 = 0.

## Structure
- Package `arbitro_pkg` holds:
  - state enum: IDLE = 2'd0, ACTIVE = 2'd1, STALL = 2'd2.
  - `NUM_Q = 4`.
  - `QIDX_W = 2`.
- Sub-module `rr_pick`: combinational rotate-priority finder with inputs `empty[3:0]` and `cur[1:0]`, outputs `g[1:0]` and `valid`. It is instantiated once.
- Everything else (FSM, counters, output registers) is in `arbitro_rr`.
- Gate-level synthesized twin `arbitro_rr_estr` is compared cycle-by-cycle in the same bench.

## Test plan
- **Reset:** hold `reset` for 2 cycles with all queues non-empty → `pop` = 0, `push` = 0, `idle` = 1 throughout; first pop is `pop = 4'b0001` two cycles after release.
- **Weighted rotation:** `WEIGHT` = 2, all queues deep, `almost_full` = 0 → pop sequence 0,0,1,1,2,2,3,3,0; `sel` trails `pop` by exactly 1 cycle.
- **Skip empty owner:** `empty = 4'b0101`, `cur` = 0 → grants alternate 1,1,3,3; queues 0 and 2 are never popped.
- **Backpressure:** raise `almost_full` mid-burst at `cnt` = 1 → `pop` = 0 the same cycle, state STALL next cycle; on release, the same queue completes 1 more grant.
- **Single-entry drain:** queue 2 holds 1 word, others empty → exactly one `pop[2]`, one `push`, `sel` = 2, then IDLE.
- **Equivalence:** random `empty`/`almost_full` for 2000 cycles → `pop`, `push`, `sel`, `idle` match `arbitro_rr_estr` every cycle.

Source files
------------

// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types and sizes for the weighted round-robin merge scheduler
package arbitro_pkg;

  localparam int NUM_Q  = 4;
  localparam int QIDX_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-priority finder: first non-empty queue starting at the owner
module rr_pick
  import arbitro_pkg::*;
(
  input  logic [NUM_Q-1:0]  empty,
  input  logic [QIDX_W-1:0] cur,
  output logic [QIDX_W-1:0] g,
  output logic              valid
);

  logic [QIDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest non-empty queue wins;
  // offset 0 is the owner itself, so a non-empty owner keeps the grant.
  always_comb begin
    g     = cur;
    valid = 1'b0;
    idx   = cur;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      idx = cur + QIDX_W'(i);
      if (!empty[idx]) begin
        g     = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - weighted round-robin drain of four class queues into one downstream FIFO
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int WEIGHT = 2,
  parameter int CNT_W  = $clog2(WEIGHT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_Q-1:0]  empty,
  input  logic              almost_full,
  output logic [NUM_Q-1:0]  pop,
  output logic [QIDX_W-1:0] sel,
  output logic              push,
  output logic              idle
);

  state_t            state;
  state_t            state_next;
  logic [QIDX_W-1:0] cur;
  logic [CNT_W-1:0]  cnt;
  logic [QIDX_W-1:0] g;
  logic              valid;
  logic [CNT_W-1:0]  n;
  logic              do_pop;

  rr_pick u_pick (
    .empty (empty),
    .cur   (cur),
    .g     (g),
    .valid (valid)
  );

  // Next state and pop strobe; almost_full and reset veto a pop in the same cycle.
  always_comb begin
    state_next = state;
    pop        = '0;
    do_pop     = 1'b0;
    n          = ((g == cur) ? cnt : '0) + CNT_W'(1);
    case (state)
      IDLE: begin
        if (empty != 4'hF && !almost_full) state_next = ACTIVE;
      end
      ACTIVE: begin
        do_pop = !almost_full && valid && !reset;
        if (almost_full)         state_next = STALL;
        else if (empty == 4'hF)  state_next = IDLE;
      end
      STALL: begin
        if (!almost_full) state_next = (empty == 4'hF) ? IDLE : ACTIVE;
      end
      default: state_next = IDLE;
    endcase
    if (do_pop) pop[g] = 1'b1;
  end

  // State, burst accounting and the one-cycle-delayed push/select toward the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      sel   <= '0;
      push  <= 1'b0;
      idle  <= 1'b1;
    end else begin
      state <= state_next;
      push  <= do_pop;
      sel   <= g;
      idle  <= (state_next == IDLE);
      if (do_pop) begin
        if (n == CNT_W'(WEIGHT)) begin
          cur <= g + QIDX_W'(1);
          cnt <= '0;
        end else begin
          cur <= g;
          cnt <= n;
        end
      end
    end
  end

endmodule
